// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer for a show-ahead FIFO. Pops narrow words and packs
//   PACK consecutive words into one wide beat, least significant word first.
//   Each beat goes through a 2-entry output buffer with a registered
//   valid/ready interface, so the pop decision never depends on out_ready.
//
// Ports
//   clk          single clock
//   rst          asynchronous, active-high reset
//   fifo_rdata   FIFO head word (valid while fifo_rempty=0)
//   fifo_rempty  FIFO empty flag
//   fifo_rpop    pops the FIFO head this cycle
//   flush        discards the partially assembled beat
//   out_data     head beat of the output buffer
//   out_valid    output buffer non-empty
//   out_ready    consumer accepts the head beat this cycle
//   partial      1..PACK-1 words are held in the accumulator
module fifo_rd_packer #(
    parameter int W_DATA = 16,
    parameter int PACK   = 4,
    parameter int W_OUT  = W_DATA * PACK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DATA-1:0] fifo_rdata,
    input  logic              fifo_rempty,
    output logic              fifo_rpop,
    input  logic              flush,
    output logic [W_OUT-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              partial
);

    localparam int              W_CNT = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [W_CNT-1:0] LAST = W_CNT'(PACK - 1);

    logic [W_CNT-1:0] count;
    logic [W_CNT-1:0] count_next;
    logic [W_OUT-1:0] acc;
    logic [W_OUT-1:0] beat;
    logic [W_OUT-1:0] spare;     // second buffer entry, behind out_data
    logic [1:0]       level;
    logic             at_last;
    logic             can_accept;
    logic             push;
    logic             handshake;

    // The last word of a beat may only be popped if the buffer has room;
    // earlier words are always accepted. Depends on registered state only.
    assign at_last    = (count == LAST);
    assign can_accept = !at_last || (level != 2'd2);
    assign fifo_rpop  = !fifo_rempty && can_accept && !flush && !rst;
    assign push       = fifo_rpop && at_last;
    assign handshake  = out_valid && out_ready;

    // Completed beat: stored words plus the word being popped now in the top
    // slot. Written generically so PACK=1 degenerates to the word itself.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        beat = acc;
        beat[(PACK-1)*W_DATA +: W_DATA] = fifo_rdata;
    end

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (fifo_rpop) begin
            count_next = at_last ? '0 : count + W_CNT'(1);
        end
    end

    // Accumulator. After a flush its data is stale but harmless: every slot
    // below the top is rewritten before the next beat completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from before the clock edge.
            count   <= '0;
            acc     <= '0;
            partial <= 1'b0;
        end else begin
            count   <= count_next;
            partial <= (count_next != '0);
            if (fifo_rpop && !at_last) begin
                acc[count*W_DATA +: W_DATA] <= fifo_rdata;
            end
        end
    end

    // Two-entry output buffer: out_data is the head, spare the tail.
    // A push at level 2 cannot happen because can_accept blocks it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: both buffer entries are plain registers and are reset, so
            // out_data reads 0 and no stale beat survives a reset.
            level     <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            spare     <= '0;
        end else begin
            unique case ({push, handshake})
                2'b10: begin
                    if (level == 2'd0) begin
                        out_data <= beat;
                    end else begin
                        spare <= beat;
                    end
                    level     <= level + 2'd1;
                    out_valid <= 1'b1;
                end
                2'b01: begin
                    out_data  <= spare;
                    level     <= level - 2'd1;
                    out_valid <= (level == 2'd2);
                end
                2'b11: begin
                    // Only reachable at level 1: head leaves, new beat
                    // takes its place, level unchanged.
                    out_data <= beat;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
